// File: rtl/gps_regbank_pkg.sv
// Shared register-map constants and staged-field layout for the satellite parameter bank.
package gps_regbank_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_STATUS = 1;
  localparam int ADDR_ID     = 2;

  localparam int CH_BASE   = 8;
  localparam int CH_STRIDE = 8;
  localparam int CH_SHIFT  = $clog2(CH_STRIDE);

  localparam logic [CH_SHIFT-1:0] OFF_DOP     = 3'd0;
  localparam logic [CH_SHIFT-1:0] OFF_GAIN    = 3'd1;
  localparam logic [CH_SHIFT-1:0] OFF_CA      = 3'd2;
  localparam logic [CH_SHIFT-1:0] OFF_CODE    = 3'd3;
  localparam logic [CH_SHIFT-1:0] OFF_RATE    = 3'd4;
  localparam logic [CH_SHIFT-1:0] OFF_EN      = 3'd5;
  localparam logic [CH_SHIFT-1:0] OFF_ACT_DOP = 3'd6;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_SYNC_BIT   = 1;

  localparam logic [31:0] ID_BASE = 32'h6B50_0000;

  // Staged words are held at register-word width; narrow fields are masked on write.
  typedef struct packed {
    logic [31:0] dop_freq;
    logic [31:0] gain;
    logic [31:0] ca_sel;
    logic [31:0] code_freq;
    logic [31:0] dop_rate;
    logic        en;
  } sat_param_t;

  function automatic logic [31:0] mask_w(input logic [31:0] d, input int w);
    return d & 32'((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/gps_sat_chan_regs.sv
// One satellite channel: staged registers, active registers loaded on commit,
// and the per-epoch Doppler ramp adder.
module gps_sat_chan_regs
  import gps_regbank_pkg::*;
#(
  parameter int FREQ_W = 32,
  parameter int GAIN_W = 16,
  parameter int CA_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CH_SHIFT-1:0] wr_off,
  input  logic [31:0]         wr_data,
  input  logic                commit,
  input  logic                epoch,
  input  logic [CH_SHIFT-1:0] rd_off,
  output logic [FREQ_W-1:0]   dop_freq,
  output logic [FREQ_W-1:0]   code_freq,
  output logic [GAIN_W-1:0]   gain,
  output logic [CA_W-1:0]     ca_sel,
  output logic                en,
  output logic [31:0]         rd_word
);

  sat_param_t  staged;
  logic [31:0] rate_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      staged    <= '0;
      rate_act  <= '0;
      dop_freq  <= '0;
      code_freq <= '0;
      gain      <= '0;
      ca_sel    <= '0;
      en        <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_off)
          OFF_DOP:  staged.dop_freq  <= mask_w(wr_data, FREQ_W);
          OFF_GAIN: staged.gain      <= mask_w(wr_data, GAIN_W);
          OFF_CA:   staged.ca_sel    <= mask_w(wr_data, CA_W);
          OFF_CODE: staged.code_freq <= mask_w(wr_data, FREQ_W);
          OFF_RATE: staged.dop_rate  <= wr_data;
          OFF_EN:   staged.en        <= wr_data[0];
          default:  ;
        endcase
      end
      // Commit beats the ramp: the freshly loaded value is not advanced this cycle.
      if (commit) begin
        dop_freq  <= staged.dop_freq[FREQ_W-1:0];
        code_freq <= staged.code_freq[FREQ_W-1:0];
        gain      <= staged.gain[GAIN_W-1:0];
        ca_sel    <= staged.ca_sel[CA_W-1:0];
        en        <= staged.en;
        rate_act  <= staged.dop_rate;
      end else if (epoch && en) begin
        dop_freq <= dop_freq + rate_act[FREQ_W-1:0];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_off)
      OFF_DOP:     rd_word = staged.dop_freq;
      OFF_GAIN:    rd_word = staged.gain;
      OFF_CA:      rd_word = staged.ca_sel;
      OFF_CODE:    rd_word = staged.code_freq;
      OFF_RATE:    rd_word = staged.dop_rate;
      OFF_EN:      rd_word = {31'd0, staged.en};
      OFF_ACT_DOP: rd_word = 32'(dop_freq);
      default:     rd_word = '0;
    endcase
  end

endmodule

// File: rtl/gps_sat_param_bank.sv
// Double-buffered satellite parameter bank: address decode, commit sequencing,
// commit counter and registered read port in front of NSAT channel register sets.
//
//   state       | meaning
//   IDLE        | no commit armed
//   ARMED_IMM   | commit executes at the next edge
//   ARMED_EPOCH | commit executes at the next edge with epoch high
module gps_sat_param_bank
  import gps_regbank_pkg::*;
#(
  parameter int NSAT   = 4,
  parameter int FREQ_W = 32,
  parameter int GAIN_W = 16,
  parameter int CA_W   = 6,
  parameter int ADDR_W = $clog2(CH_BASE + CH_STRIDE * NSAT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              epoch,
  output logic [FREQ_W-1:0] dop_freq  [NSAT],
  output logic [FREQ_W-1:0] code_freq [NSAT],
  output logic [GAIN_W-1:0] gain      [NSAT],
  output logic [CA_W-1:0]   ca_sel    [NSAT],
  output logic [NSAT-1:0]   sat_en,
  output logic              pending,
  output logic              commit_done
);

  localparam int IDX_W = ADDR_W - CH_SHIFT;

  typedef enum logic [1:0] {IDLE, ARMED_IMM, ARMED_EPOCH} state_t;

  state_t              state;
  logic                epoch_sync;
  logic [7:0]          commit_cnt;
  logic                ctrl_wr;
  logic                commit_now;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [CH_SHIFT-1:0] wr_off;
  logic [CH_SHIFT-1:0] rd_off;
  logic [31:0]         chan_rd [NSAT];
  logic [31:0]         rd_next;

  assign wr_idx = wr_addr[ADDR_W-1:CH_SHIFT];
  assign wr_off = wr_addr[CH_SHIFT-1:0];
  assign rd_idx = rd_addr[ADDR_W-1:CH_SHIFT];
  assign rd_off = rd_addr[CH_SHIFT-1:0];

  assign ctrl_wr    = wr_en && (wr_addr == ADDR_W'(ADDR_CTRL));
  assign commit_now = (state == ARMED_IMM) || ((state == ARMED_EPOCH) && epoch);

  // COMMIT writes are only accepted from IDLE, so a write while armed is dropped whole.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      commit_done <= 1'b0;
      epoch_sync  <= 1'b0;
      commit_cnt  <= '0;
    end else begin
      commit_done <= commit_now;
      case (state)
        IDLE: begin
          if (ctrl_wr && wr_data[CTRL_COMMIT_BIT]) begin
            epoch_sync <= wr_data[CTRL_SYNC_BIT];
            pending    <= 1'b1;
            state      <= wr_data[CTRL_SYNC_BIT] ? ARMED_EPOCH : ARMED_IMM;
          end
        end
        ARMED_IMM, ARMED_EPOCH: begin
          if (commit_now) begin
            pending    <= 1'b0;
            commit_cnt <= commit_cnt + 8'd1;
            state      <= IDLE;
          end
        end
        default: begin
          pending <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NSAT; c++) begin : g_chan
    gps_sat_chan_regs #(
      .FREQ_W (FREQ_W),
      .GAIN_W (GAIN_W),
      .CA_W   (CA_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en && (wr_idx == IDX_W'(c + 1))),
      .wr_off    (wr_off),
      .wr_data   (wr_data),
      .commit    (commit_now),
      .epoch     (epoch),
      .rd_off    (rd_off),
      .dop_freq  (dop_freq[c]),
      .code_freq (code_freq[c]),
      .gain      (gain[c]),
      .ca_sel    (ca_sel[c]),
      .en        (sat_en[c]),
      .rd_word   (chan_rd[c])
    );
  end

  always_comb begin
    rd_next = '0;
    if (rd_idx == '0) begin
      case (rd_off)
        CH_SHIFT'(ADDR_STATUS): rd_next = {16'd0, commit_cnt, 6'd0, epoch_sync, pending};
        CH_SHIFT'(ADDR_ID):     rd_next = ID_BASE | 32'(NSAT);
        default:                rd_next = '0;
      endcase
    end else begin
      for (int c = 0; c < NSAT; c++) begin
        if (rd_idx == IDX_W'(c + 1)) rd_next = chan_rd[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_next;
  end

endmodule

// File: doc/gps_sat_param_bank.md
# gps_sat_param_bank

Parametrised, double-buffered parameter bank for the GPS emulator's satellite channels. Software writes per-channel Doppler frequency, Doppler rate, code frequency, gain, C/A select and enable into staged registers through a simple word-addressed write/read port. A commit transfers all staged values atomically to the active outputs, either immediately or on the next 1 ms code-epoch pulse. Between commits, each channel's active Doppler frequency is ramped once per epoch by its programmed rate. The block sits between the AXI register file and `gps_emulator`, and replaces the direct register-to-channel wiring.

## Interface
Parameters:
- `NSAT`, 4 — number of satellite channels (1..16).
- `FREQ_W`, 32 — width of the Doppler and code frequency words.
- `GAIN_W`, 16 — width of the gain word.
- `CA_W`, 6 — width of the C/A select word.
- `ADDR_W`, `$clog2(8+8*NSAT)` — word address width (derived; do not override).

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high reset.
- `wr_en` in 1 — register write strobe.
- `wr_addr` in ADDR_W — word address of the write.
- `wr_data` in 32 — write data.
- `rd_addr` in ADDR_W — word address of the read.
- `rd_data` out 32 — read data, registered.
- `epoch` in 1 — one-cycle pulse at each code epoch.
- `dop_freq[NSAT]` out FREQ_W — active Doppler frequency per channel.
- `code_freq[NSAT]` out FREQ_W — active code frequency per channel.
- `gain[NSAT]` out GAIN_W — active gain per channel.
- `ca_sel[NSAT]` out CA_W — active C/A select per channel.
- `sat_en` out NSAT — active per-channel enable.
- `pending` out 1 — a commit is armed and not yet executed.
- `commit_done` out 1 — one-cycle pulse when a commit executes.

## Operation
Register map (word addresses):
- **0, CTRL** (write-only):
  - bit0 `COMMIT` — write-1 arms a commit.
  - bit1 `EPOCH_SYNC` — 0 means the commit executes immediately; 1 means it executes on the next `epoch`. Latched from the same write.
- **1, STATUS** (read-only):
  - bit0 `pending`.
  - bit1 latched `EPOCH_SYNC`.
  - bits[15:8] commit counter, 8-bit, wraps 255→0.
- **2, ID** (read-only): returns 32'h6B50_0000 | NSAT.
- **Channel c base** = 8 + 8*c:
  - +0 staged `dop_freq`.
  - +1 staged `gain` (low GAIN_W bits).
  - +2 staged `ca_sel` (low CA_W bits).
  - +3 staged `code_freq`.
  - +4 staged `dop_rate`, signed 32-bit.
  - +5 staged enable (bit0).
  - +6 active `dop_freq` (read-only).
- Reads of staged registers return the staged value, zero-extended. Unmapped reads return 0. Unmapped writes, and writes to read-only words, are ignored.

Commit:
- Commit loads all active fields from staged, for all channels, in one cycle.
- Commit loads `dop_freq` and the rate; the ramp restarts from the newly loaded value.
- A COMMIT write while `pending`=1 is ignored, including its EPOCH_SYNC bit.

Ramp:
- On every `epoch` cycle with no commit, each enabled channel updates `dop_freq <= dop_freq + dop_rate`, modulo 2^FREQ_W (wraps, no saturation).
- Disabled channels hold their value.

Boundary rules:
- **Commit and epoch in the same cycle:** the commit wins; load only, no ramp add that cycle.
- **Write to a staged register in the same cycle as a commit:** the commit uses the pre-write staged value; the write lands in staged.
- **Reset, including mid-pending:** every staged register, active output, `pending`, EPOCH_SYNC, the counter, `rd_data` and `commit_done` go to 0.

## Timing
- Writes take effect in staged registers one cycle after the `wr_en` edge.
- `rd_data` is valid one cycle after `rd_addr` (1-cycle latency), for every address.
- **Immediate mode:**
  - COMMIT write sampled at edge t → `pending`=1 after t.
  - Active outputs load at edge t+1.
  - `pending`=0 and `commit_done`=1 after t+1, for one cycle.
- **Epoch mode:** the commit executes at the first edge t' ≥ t+1 where `epoch`=1. An `epoch` in the write cycle t itself does not qualify.
- **Ramp:** the active update occurs at the `epoch` edge and is visible the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `gps_regbank_pkg`:
  - `CTRL`/`STATUS`/`ID` addresses, `CH_BASE`=8, `CH_STRIDE`=8, the channel offset constants and CTRL bit positions.
  - Typedef `sat_param_t`, a struct of the staged fields.
- Sub-module `gps_sat_chan_regs`, generated NSAT times: per-channel staged registers, active registers and ramp adder. Inputs: decoded write, commit strobe, `epoch`. Outputs: active fields and a read mux.
- Top level: address decode, commit FSM (IDLE → ARMED_IMM or ARMED_EPOCH → IDLE), counter, read mux register.

## Test plan
- **Reset values:** reset asserted with arbitrary writes → all outputs 0, STATUS reads 0, ID reads 32'h6B50_0004.
- **Immediate commit:**
  - Stage ch2 `dop_freq`=32'h0001_0000 and `ca_sel`=17, then write CTRL=1.
  - Outputs update exactly 2 cycles after the write; `commit_done` pulses once; STATUS[15:8]=1.
- **Epoch commit:**
  - Write CTRL=3, then pulse `epoch` 10 cycles later.
  - Outputs unchanged until the epoch edge; `pending`=1 in between; a second CTRL=1 write during pending is ignored.
- **Ramp with wrap:**
  - Ch0 `dop_freq`=32'hFFFF_FFF0, `dop_rate`=32, enabled, committed.
  - After one epoch, `dop_freq`=32'h0000_0010. With `dop_rate`=-16, `dop_freq` decreases by 16 per epoch.
- **Simultaneous events:** commit, epoch and a staged write to ch0 +0 all in one cycle → active equals the old staged value with no ramp add; a read of +0 returns the new value.
- **Reset mid-pending:** arm in epoch mode, assert `reset` for 1 cycle, then pulse `epoch` → no commit, `commit_done` stays 0.
